// File: rtl/sens_histogram_rcv.sv
// Receiving end of the histogram readout channel: grants a channel set when the
// buffer has room, writes NUM_BURSTS dv-framed bursts and flags protocol errors.
module sens_histogram_rcv #(
  parameter int BURST_LOG2 = 8,
  parameter int NUM_BURSTS = 4,
  parameter int ADDR_BITS  = 12
) (
  input  logic                 mclk,
  input  logic                 mrst,
  input  logic                 en,
  input  logic                 buf_ready,
  input  logic                 err_clr,
  input  logic                 rq,
  output logic                 grant,
  input  logic [1:0]           chn,
  input  logic                 dv,
  input  logic [31:0]          din,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 done,
  output logic [1:0]           done_chn,
  output logic [2:0]           err
);

  localparam int BW = $clog2(NUM_BURSTS);
  localparam logic [BURST_LOG2:0] WORDS      = {1'b1, {BURST_LOG2{1'b0}}};
  localparam logic [BURST_LOG2:0] WORD_ONE   = {{BURST_LOG2{1'b0}}, 1'b1};
  localparam logic [BW-1:0]       LAST_BURST = BW'(NUM_BURSTS - 1);
  localparam logic [BW-1:0]       BURST_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RECV = 2'd2, GAP = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic [BW-1:0]          burst_q, burst_d;
  logic [BURST_LOG2:0]    word_q, word_d;
  logic [1:0]             chn_l_q, chn_l_d;
  logic                   dv_d_q, dv_d_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic                   done_q, done_d;
  logic [1:0]             done_chn_q, done_chn_d;
  logic [2:0]             err_q, err_d;
  logic [2:0]             err_set;

  // Next-state, write pipeline and error detection
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    burst_d    = burst_q;
    word_d     = word_q;
    chn_l_d    = chn_l_q;
    dv_d_d     = dv;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    done_chn_d = done_chn_q;
    err_set    = 3'b000;

    if (!en) begin
      state_d = IDLE;
      grant_d = 1'b0;
      burst_d = '0;
      word_d  = '0;
      dv_d_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          burst_d    = '0;
          word_d     = '0;
          err_set[2] = dv;
          if (rq && buf_ready) begin
            state_d = GRANT;
            grant_d = 1'b1;
          end else begin
            grant_d = 1'b0;
          end
        end
        GRANT: begin
          if (dv) begin
            chn_l_d   = chn;
            state_d   = RECV;
            wr_en_d   = 1'b1;
            wr_addr_d = {chn, burst_q, word_q[BURST_LOG2-1:0]};
            wr_data_d = din;
            word_d    = word_q + WORD_ONE;
          end else begin
            state_d = GRANT;
          end
        end
        RECV: begin
          if (dv) begin
            err_set[2] = (chn != chn_l_q);
            if (word_q < WORDS) begin
              wr_en_d   = 1'b1;
              wr_addr_d = {chn_l_q, burst_q, word_q[BURST_LOG2-1:0]};
              wr_data_d = din;
              word_d    = word_q + WORD_ONE;
            end else begin
              err_set[1] = 1'b1;
            end
          end else if (dv_d_q) begin
            // falling edge of dv closes the burst
            err_set[0] = (word_q != WORDS);
            word_d     = '0;
            if (burst_q == LAST_BURST) begin
              state_d    = GAP;
              grant_d    = 1'b0;
              done_d     = 1'b1;
              done_chn_d = chn_l_q;
            end else begin
              burst_d = burst_q + BURST_ONE;
            end
          end else begin
            state_d = RECV;
          end
        end
        GAP: begin
          grant_d    = 1'b0;
          state_d    = IDLE;
          err_set[2] = dv;
        end
        default: begin
          state_d = IDLE;
          grant_d = 1'b0;
        end
      endcase
    end

    err_d = (err_clr ? 3'b000 : err_q) | err_set;
  end

  // State and output registers
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      burst_q    <= '0;
      word_q     <= '0;
      chn_l_q    <= 2'b00;
      dv_d_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'h0000_0000;
      done_q     <= 1'b0;
      done_chn_q <= 2'b00;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      burst_q    <= burst_d;
      word_q     <= word_d;
      chn_l_q    <= chn_l_d;
      dv_d_q     <= dv_d_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      done_chn_q <= done_chn_d;
      err_q      <= err_d;
    end
  end

  assign grant    = grant_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign done_chn = done_chn_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sens_histogram_rcv.sv
// Scoreboard bench for sens_histogram_rcv: expected writes and done events are
// queued as stimulus is issued and a forked monitor compares DUT outputs.
module tb_sens_histogram_rcv;

  logic        mclk = 1'b0;
  logic        mrst, en, buf_ready, err_clr, rq, dv;
  logic [1:0]  chn;
  logic [31:0] din;
  logic        grant, wr_en, done;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  done_chn;
  logic [2:0]  err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [43:0] wr_exp_q[$];
  logic [1:0]  done_exp_q[$];
  logic [2:0]  exp_err = 3'b000;

  localparam int NO_SWITCH = 100000;

  sens_histogram_rcv #(.BURST_LOG2(8), .NUM_BURSTS(4), .ADDR_BITS(12)) dut (
    .mclk(mclk), .mrst(mrst), .en(en), .buf_ready(buf_ready), .err_clr(err_clr),
    .rq(rq), .grant(grant), .chn(chn), .dv(dv), .din(din), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .done_chn(done_chn), .err(err)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [43:0] e;
    logic [1:0]  c;
    forever begin
      @(negedge mclk);
      if (!mrst && wr_en) begin
        n_vec++;
        if (wr_exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got addr %h data %h, no write expected", wr_addr, wr_data);
        end else begin
          e = wr_exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_err++;
            $display("FAIL wr_word: got addr %h data %h expected addr %h data %h",
                     wr_addr, wr_data, e[43:32], e[31:0]);
          end
        end
      end
      if (!mrst && done) begin
        n_vec++;
        if (done_exp_q.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected: got done_chn %0d, no done expected", done_chn);
        end else begin
          c = done_exp_q.pop_front();
          if (done_chn !== c) begin
            n_err++;
            $display("FAIL done_chn: got %0d expected %0d", done_chn, c);
          end
        end
      end
    end
  endtask

  task automatic wait_grant();
    int k = 0;
    while (!grant && k < 20) begin
      tick();
      k++;
    end
    check("grant_wait", grant, 1);
  endtask

  // One dv-framed burst; cl is the channel the receiver should have latched.
  task automatic send_burst(input logic [1:0] cl, input logic [1:0] ca, input logic [1:0] cb,
                            input int sw, input int b, input int n, input bit nom);
    logic [1:0] bb;
    logic [7:0] jj;
    bb = b[1:0];
    for (int j = 0; j < n; j++) begin
      dv  = 1'b1;
      chn = (j < sw) ? ca : cb;
      din = nom ? 32'(j + b * 256) : $urandom;
      if (chn != cl) exp_err[2] = 1'b1;
      if (j < 256) begin
        jj = j[7:0];
        wr_exp_q.push_back({cl, bb, jj, din});
      end
      tick();
    end
    dv = 1'b0;
    if (n < 256) exp_err[0] = 1'b1;
    if (n > 256) exp_err[1] = 1'b1;
    tick();
  endtask

  task automatic readout(input logic [1:0] cl, input logic [1:0] alt, input int sw,
                         input int l0, input int l1, input int l2, input int l3,
                         input bit nom, input bit hold);
    int lens[4];
    lens = '{l0, l1, l2, l3};
    rq  = 1'b1;
    chn = cl;
    wait_grant();
    if (!hold) rq = 1'b0;
    done_exp_q.push_back(cl);
    for (int b = 0; b < 4; b++) begin
      send_burst(cl, cl, (b == 0) ? alt : cl, sw, b, lens[b], nom);
      if (b < 3) repeat (nom ? 2 : $urandom_range(0, 3)) tick();
    end
    check("done_pulse", done, 1);
    check("grant_drop", grant, 0);
  endtask

  initial begin
    logic [1:0] c;
    mrst = 1'b1; en = 1'b0; buf_ready = 1'b0; err_clr = 1'b0; rq = 1'b0;
    dv = 1'b0; chn = 2'b00; din = 32'h0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge mclk);
    #1;
    check("reset_outs", {grant, wr_en, wr_addr, wr_data, done, done_chn, err}, 0);
    @(negedge mclk);
    mrst = 1'b0;
    en   = 1'b1;
    tick();

    // backpressure, then nominal channel 2 readout
    rq = 1'b1; chn = 2'd2;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_grant_low", grant, 0);
    end
    buf_ready = 1'b1;
    tick();
    check("bp_grant_high", grant, 1);
    readout(2'd2, 2'd2, NO_SWITCH, 256, 256, 256, 256, 1'b1, 1'b0);
    check("nominal_err", err, exp_err);
    tick();

    // short and long bursts
    readout(2'd1, 2'd1, NO_SWITCH, 256, 255, 258, 256, 1'b0, 1'b0);
    check("short_long_err", err, 3'b011);
    check("short_long_model", err, exp_err);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 3'b000;
    check("err_clr", err, exp_err);

    // back-to-back channels with rq held high
    readout(2'd0, 2'd0, NO_SWITCH, 256, 256, 256, 256, 1'b0, 1'b1);
    tick();
    check("b2b_grant_low2", grant, 0);
    tick();
    check("b2b_regrant", grant, 1);
    readout(2'd3, 2'd3, NO_SWITCH, 256, 256, 256, 256, 1'b0, 1'b0);
    check("b2b_err", err, 3'b000);
    tick();

    // dv while idle, then channel change mid-burst
    dv = 1'b1; din = $urandom;
    exp_err[2] = 1'b1;
    tick();
    dv = 1'b0;
    check("idle_dv_wr_en", wr_en, 0);
    check("idle_dv_err", err, exp_err);
    err_clr = 1'b1; tick(); err_clr = 1'b0; exp_err = 3'b000;
    readout(2'd1, 2'd2, 100, 256, 256, 256, 256, 1'b0, 1'b0);
    check("chn_change_err", err, 3'b100);
    check("chn_change_model", err, exp_err);
    err_clr = 1'b1; tick(); err_clr = 1'b0; exp_err = 3'b000;

    // abort with en low during burst 2, word 100
    rq = 1'b1; chn = 2'd0;
    wait_grant();
    rq = 1'b0;
    send_burst(2'd0, 2'd0, 2'd0, NO_SWITCH, 0, 256, 1'b0);
    send_burst(2'd0, 2'd0, 2'd0, NO_SWITCH, 1, 256, 1'b0);
    for (int j = 0; j < 100; j++) begin
      dv = 1'b1;
      din = $urandom;
      wr_exp_q.push_back({2'd0, 2'd2, 8'(j), din});
      tick();
    end
    en = 1'b0; din = $urandom;
    tick();
    check("abort_grant", grant, 0);
    check("abort_wr_en", wr_en, 0);
    dv = 1'b0;
    tick();
    en = 1'b1;
    c = 2'($urandom_range(0, 3));
    readout(c, c, NO_SWITCH, 256, 256, 256, 256, 1'b0, 1'b0);
    check("restart_err", err, exp_err);
    tick();

    // asynchronous reset mid-burst
    rq = 1'b1; chn = 2'd3;
    wait_grant();
    rq = 1'b0;
    for (int j = 0; j < 50; j++) begin
      dv = 1'b1;
      din = $urandom;
      wr_exp_q.push_back({2'd3, 2'd0, 8'(j), din});
      tick();
    end
    @(negedge mclk);
    #1;
    mrst = 1'b1;
    dv   = 1'b0;
    exp_err = 3'b000;
    #1;
    check("mrst_outs", {grant, wr_en, wr_addr, wr_data, done, done_chn, err}, 0);
    @(negedge mclk);
    mrst = 1'b0;
    tick();
    c = 2'($urandom_range(0, 3));
    readout(c, c, NO_SWITCH, 256, 256, 256, 256, 1'b0, 1'b0);
    tick();
    repeat (3) tick();

    check("wr_queue_empty", wr_exp_q.size(), 0);
    check("done_queue_empty", done_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
